// File: rtl/psum_su_adder_drain.sv
// Drains the idle half of the psum RF array: broadcasts a read address, reduces
// the NUM_PE returned words and writes one sum per entry to the global buffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; address and overrun flag hold their values
// S_ISSUE | read address idx presented, RFs register out1/out2
// S_SUM   | reduce the selected RF outputs into sum_q
// S_WRITE | global-buffer write valid, held until gb_ready
// S_DONE  | one-cycle done pulse
module psum_su_adder_drain #(
    parameter int unsigned DATA_BITWIDTH    = 16,
    parameter int unsigned ADDR_BITWIDTH    = 2,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned NUM_PE           = 4,
    parameter int unsigned GB_ADDR_BITWIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            en1,
    input  logic [GB_ADDR_BITWIDTH-1:0]     base_addr,
    input  logic [NUM_PE*DATA_BITWIDTH-1:0] pe_out1,
    input  logic [NUM_PE*DATA_BITWIDTH-1:0] pe_out2,
    output logic [ADDR_BITWIDTH-1:0]        addr_from_su_adder,
    output logic                            gb_w_en,
    output logic [GB_ADDR_BITWIDTH-1:0]     gb_w_addr,
    output logic [DATA_BITWIDTH-1:0]        gb_w_data,
    input  logic                            gb_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SUM,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(DEPTH - 1);

    state_t                        state_q, state_d;
    logic                          sel_q, sel_d;
    logic [GB_ADDR_BITWIDTH-1:0]   base_q, base_d;
    logic [ADDR_BITWIDTH-1:0]      idx_q, idx_d;
    logic [DATA_BITWIDTH-1:0]      sum_q, sum_d;
    logic                          overrun_q, overrun_d;

    logic [NUM_PE*DATA_BITWIDTH-1:0] pe_sel;
    logic [DATA_BITWIDTH-1:0]        pe_sum;
    logic                            draining;

    // Reduction wraps modulo 2^DATA_BITWIDTH; carries are simply dropped.
    always_comb begin
        pe_sel = sel_q ? pe_out2 : pe_out1;
        pe_sum = '0;
        for (int k = 0; k < int'(NUM_PE); k++) begin
            pe_sum = pe_sum + pe_sel[k*DATA_BITWIDTH +: DATA_BITWIDTH];
        end
    end

    assign draining = (state_q == S_ISSUE) || (state_q == S_SUM) || (state_q == S_WRITE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        base_d    = base_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d     = en1;
                    base_d    = base_addr;
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_SUM;
            S_SUM: begin
                sum_d   = pe_sum;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (gb_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_BITWIDTH'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A buffer swap mid-drain means the RF is clearing what we read: abandon.
        if (draining && (en1 != sel_q)) begin
            overrun_d = 1'b1;
            idx_d     = idx_q;
            sum_d     = sum_q;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            base_q    <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            overrun_q <= overrun_d;
        end
    end

    assign addr_from_su_adder = idx_q;
    assign gb_w_en            = (state_q == S_WRITE);
    assign gb_w_addr          = base_q + GB_ADDR_BITWIDTH'(idx_q);
    assign gb_w_data          = sum_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_psum_su_adder_drain.sv
// Directed bench for psum_su_adder_drain with a registered RF read model.
module tb_psum_su_adder_drain;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int NPE = 4;
    localparam int GBW = 8;

    logic              clk, reset, start, en1, gb_ready;
    logic [GBW-1:0]    base_addr;
    logic [NPE*DW-1:0] pe_out1, pe_out2;
    logic [AW-1:0]     addr_from_su_adder;
    logic              gb_w_en, busy, done, overrun;
    logic [GBW-1:0]    gb_w_addr;
    logic [DW-1:0]     gb_w_data;

    logic [DW-1:0] mem1 [NPE][DEPTH];
    logic [DW-1:0] mem2 [NPE][DEPTH];

    int n_pass = 0;
    int n_total = 0;

    logic [GBW-1:0] wr_addr [$];
    logic [DW-1:0]  wr_data [$];
    int done_cyc, busy_cnt, max_en_run;
    bit hold_bad;

    psum_su_adder_drain #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .DEPTH(DEPTH),
        .NUM_PE(NPE), .GB_ADDR_BITWIDTH(GBW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .en1(en1), .base_addr(base_addr),
        .pe_out1(pe_out1), .pe_out2(pe_out2), .addr_from_su_adder(addr_from_su_adder),
        .gb_w_en(gb_w_en), .gb_w_addr(gb_w_addr), .gb_w_data(gb_w_data),
        .gb_ready(gb_ready), .busy(busy), .done(done), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RF read port: one-cycle registered read of the broadcast address.
    always @(posedge clk) begin
        for (int p = 0; p < NPE; p++) begin
            pe_out1[p*DW +: DW] <= mem1[p][addr_from_su_adder];
            pe_out2[p*DW +: DW] <= mem2[p][addr_from_su_adder];
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    // Runs one pass and records accepted writes; cycle k means cycle t+k after start edge t.
    task automatic run_pass(input logic [GBW-1:0] b, input logic s, input int stall_entry,
                            input int stall_n, input int inject_k);
        int k, stall_left, en_run;
        logic [GBW-1:0] prev_a;
        logic [DW-1:0]  prev_d;
        wr_addr.delete();
        wr_data.delete();
        done_cyc = -1; busy_cnt = 0; max_en_run = 0; hold_bad = 0; en_run = 0;
        prev_a = '0; prev_d = '0;
        stall_left = stall_n;
        @(negedge clk);
        en1 = s; base_addr = b; start = 1'b1; gb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k <= 40 && done_cyc < 0) begin
            if (gb_w_en && wr_addr.size() == stall_entry && stall_left > 0) begin
                gb_ready = 1'b0;
                stall_left--;
            end else begin
                gb_ready = 1'b1;
            end
            if (busy) busy_cnt++;
            if (gb_w_en) begin
                en_run++;
                if (en_run > max_en_run) max_en_run = en_run;
                if (en_run > 1 && (gb_w_addr !== prev_a || gb_w_data !== prev_d)) hold_bad = 1;
                prev_a = gb_w_addr;
                prev_d = gb_w_data;
                if (gb_ready) begin
                    wr_addr.push_back(gb_w_addr);
                    wr_data.push_back(gb_w_data);
                end
            end else begin
                en_run = 0;
            end
            if (done) done_cyc = k;
            if (k == inject_k) begin
                start = 1'b1;
                base_addr = 8'h80;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        gb_ready = 1'b1;
    endtask

    task automatic load_basic(input bit into_buf2);
        for (int p = 0; p < NPE; p++)
            for (int e = 0; e < DEPTH; e++) begin
                if (into_buf2) mem2[p][e] = DW'((e + 1) * 10);
                else           mem1[p][e] = DW'((e + 1) * 10);
            end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; en1 = 1'b0; gb_ready = 1'b1; base_addr = '0;
        #1 reset = 1'b0;
        #2;
        n_total++; if (addr_from_su_adder !== 2'd0) $display("FAIL rst_addr: got %0h expected 0", addr_from_su_adder); else n_pass++;
        n_total++; if (gb_w_en !== 1'b0) $display("FAIL rst_gb_w_en: got %0b expected 0", gb_w_en); else n_pass++;
        n_total++; if (gb_w_addr !== 8'h00) $display("FAIL rst_gb_w_addr: got %0h expected 0", gb_w_addr); else n_pass++;
        n_total++; if (gb_w_data !== 16'h0000) $display("FAIL rst_gb_w_data: got %0h expected 0", gb_w_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", done); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %0b expected 0", overrun); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_buf2;
        logic [GBW-1:0] ea [4];
        logic [DW-1:0]  ed [4];
        ea = '{8'h10, 8'h11, 8'h12, 8'h13};
        ed = '{16'd40, 16'd80, 16'd120, 16'd160};
        load_basic(1);
        run_pass(8'h10, 1'b1, -1, 0, -1);
        n_total++; if (wr_addr.size() != 4) $display("FAIL basic_count: got %0d expected 4", wr_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= wr_addr.size()) $display("FAIL basic_entry%0d: missing write expected addr %0h", i, ea[i]);
            else if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i])
                $display("FAIL basic_entry%0d: got (%0h,%0d) expected (%0h,%0d)", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            else n_pass++;
        end
        n_total++; if (done_cyc != 13) $display("FAIL basic_done_cycle: got %0d expected 13", done_cyc); else n_pass++;
        n_total++; if (busy_cnt != 13) $display("FAIL basic_busy_cycles: got %0d expected 13", busy_cnt); else n_pass++;
        n_total++; if (max_en_run != 1) $display("FAIL basic_en_run: got %0d expected 1", max_en_run); else n_pass++;
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_after_done: got done=%0b busy=%0b expected 0,0", done, busy); else n_pass++;
    endtask

    task automatic test_buf1;
        logic [GBW-1:0] ea [4];
        logic [DW-1:0]  ed [4];
        ea = '{8'h10, 8'h11, 8'h12, 8'h13};
        ed = '{16'd40, 16'd80, 16'd120, 16'd160};
        load_basic(0);
        for (int p = 0; p < NPE; p++)
            for (int e = 0; e < DEPTH; e++) mem2[p][e] = 16'hA5A5 ^ DW'(p * 16'h0111 + e * 16'h1001);
        run_pass(8'h10, 1'b0, -1, 0, -1);
        n_total++; if (wr_addr.size() != 4) $display("FAIL buf1_count: got %0d expected 4", wr_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= wr_addr.size()) $display("FAIL buf1_entry%0d: missing write expected addr %0h", i, ea[i]);
            else if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i])
                $display("FAIL buf1_entry%0d: got (%0h,%0d) expected (%0h,%0d)", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            else n_pass++;
        end
        n_total++; if (done_cyc != 13) $display("FAIL buf1_done_cycle: got %0d expected 13", done_cyc); else n_pass++;
    endtask

    task automatic test_stall;
        logic [GBW-1:0] ea [4];
        logic [DW-1:0]  ed [4];
        ea = '{8'h10, 8'h11, 8'h12, 8'h13};
        ed = '{16'd40, 16'd80, 16'd120, 16'd160};
        load_basic(1);
        run_pass(8'h10, 1'b1, 1, 3, -1);
        n_total++; if (wr_addr.size() != 4) $display("FAIL stall_count: got %0d expected 4", wr_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= wr_addr.size()) $display("FAIL stall_entry%0d: missing write expected addr %0h", i, ea[i]);
            else if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i])
                $display("FAIL stall_entry%0d: got (%0h,%0d) expected (%0h,%0d)", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            else n_pass++;
        end
        n_total++; if (max_en_run != 4) $display("FAIL stall_hold_cycles: got %0d expected 4", max_en_run); else n_pass++;
        n_total++; if (hold_bad) $display("FAIL stall_hold_stable: got changed expected stable"); else n_pass++;
        n_total++; if (done_cyc != 16) $display("FAIL stall_done_cycle: got %0d expected 16", done_cyc); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [GBW-1:0] ea [4];
        logic [DW-1:0]  ed [4];
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        ed = '{16'h8000, 16'h000A, 16'hFFFC, 16'h6000};
        for (int p = 0; p < NPE; p++) begin
            mem2[p][0] = 16'h6000;
            mem2[p][1] = DW'(p + 1);
            mem2[p][2] = 16'hFFFF;
            mem2[p][3] = DW'(p * 16'h1000);
        end
        run_pass(8'hFE, 1'b1, -1, 0, -1);
        n_total++; if (wr_addr.size() != 4) $display("FAIL wrap_count: got %0d expected 4", wr_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= wr_addr.size()) $display("FAIL wrap_entry%0d: missing write expected addr %0h", i, ea[i]);
            else if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i])
                $display("FAIL wrap_entry%0d: got (%0h,%0h) expected (%0h,%0h)", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
            else n_pass++;
        end
    endtask

    task automatic test_overrun;
        int writes;
        bit saw_done;
        logic [GBW-1:0] ea [4];
        writes = 0; saw_done = 0;
        ea = '{8'h30, 8'h31, 8'h32, 8'h33};
        load_basic(1);
        load_basic(0);
        @(negedge clk);
        en1 = 1'b1; base_addr = 8'h20; start = 1'b1; gb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            if (gb_w_en) writes++;
            @(negedge clk);
        end
        en1 = 1'b0;   // cycle t+5: second SUM
        @(negedge clk);
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %0b expected 1", overrun); else n_pass++;
        n_total++; if (gb_w_en !== 1'b0) $display("FAIL ovr_gb_w_en: got %0b expected 0", gb_w_en); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ovr_busy: got %0b expected 0", busy); else n_pass++;
        for (int k = 0; k < 15; k++) begin
            if (done) saw_done = 1;
            if (gb_w_en) writes++;
            @(negedge clk);
        end
        n_total++; if (saw_done) $display("FAIL ovr_no_done: got done pulse expected none"); else n_pass++;
        n_total++; if (writes != 1) $display("FAIL ovr_writes: got %0d expected 1", writes); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b expected 1", overrun); else n_pass++;
        run_pass(8'h30, 1'b0, -1, 0, -1);
        n_total++; if (overrun !== 1'b0) $display("FAIL ovr_cleared: got %0b expected 0", overrun); else n_pass++;
        n_total++; if (done_cyc != 13) $display("FAIL ovr_rerun_done: got %0d expected 13", done_cyc); else n_pass++;
        n_total++;
        if (wr_addr.size() != 4 || wr_addr[0] !== ea[0] || wr_addr[3] !== ea[3] || wr_data[3] !== 16'd160)
            $display("FAIL ovr_rerun_writes: got count %0d expected 4 writes 0x30..0x33 last data 160", wr_addr.size());
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        logic [GBW-1:0] ea [4];
        ea = '{8'h10, 8'h11, 8'h12, 8'h13};
        load_basic(1);
        run_pass(8'h10, 1'b1, -1, 0, 5);
        n_total++; if (wr_addr.size() != 4) $display("FAIL ign_count: got %0d expected 4", wr_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (i >= wr_addr.size()) $display("FAIL ign_entry%0d: missing write expected addr %0h", i, ea[i]);
            else if (wr_addr[i] !== ea[i]) $display("FAIL ign_entry%0d: got %0h expected %0h", i, wr_addr[i], ea[i]);
            else n_pass++;
        end
        n_total++; if (done_cyc != 13) $display("FAIL ign_done_cycle: got %0d expected 13", done_cyc); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ign_idle_after: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        load_basic(1);
        @(negedge clk);
        en1 = 1'b1; base_addr = 8'h40; start = 1'b1; gb_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);   // now in cycle t+6: second WRITE
        gb_ready = 1'b0;
        n_total++;
        if (gb_w_en !== 1'b1 || gb_w_addr !== 8'h41 || gb_w_data !== 16'd80 || addr_from_su_adder !== 2'd1)
            $display("FAIL rmw_pre: got en=%0b addr=%0h data=%0d raddr=%0d expected 1,41,80,1",
                     gb_w_en, gb_w_addr, gb_w_data, addr_from_su_adder);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (gb_w_en !== 1'b0) $display("FAIL rmw_gb_w_en: got %0b expected 0", gb_w_en); else n_pass++;
        n_total++; if (gb_w_addr !== 8'h00) $display("FAIL rmw_gb_w_addr: got %0h expected 0", gb_w_addr); else n_pass++;
        n_total++; if (gb_w_data !== 16'h0000) $display("FAIL rmw_gb_w_data: got %0h expected 0", gb_w_data); else n_pass++;
        n_total++; if (addr_from_su_adder !== 2'd0) $display("FAIL rmw_addr: got %0h expected 0", addr_from_su_adder); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0)
            $display("FAIL rmw_status: got busy=%0b done=%0b overrun=%0b expected 0,0,0", busy, done, overrun);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        gb_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0 || gb_w_en !== 1'b0)
            $display("FAIL rmw_dropped: got busy=%0b en=%0b expected 0,0", busy, gb_w_en);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_buf2();
        test_buf1();
        test_stall();
        test_wrap();
        test_overrun();
        test_start_ignored();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/psum_su_adder_drain.md
# psum_su_adder_drain

Drains a finished psum buffer from an array of `rf_psum` double-buffer RFs into the global buffer. The block sits directly downstream of the psum RFs:
- It drives the shared `addr_from_su_adder` read address into every PE's idle psum buffer.
- It sums the `NUM_PE` returned values (spatial-unrolling reduction).
- It writes one reduced word per RF entry to the global buffer through a valid/ready handshake.

## Interface
Parameters:
- DATA_BITWIDTH, 16, psum word width (RF and global-buffer word).
- ADDR_BITWIDTH, 2, RF address width.
- DEPTH, 4, RF entries to drain per pass (≤ 2^ADDR_BITWIDTH).
- NUM_PE, 4, number of PE psum RFs reduced together.
- GB_ADDR_BITWIDTH, 8, global-buffer address width.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse: begin draining the idle buffer.
- en1  in  1  buffer select from control, same signal the RFs see; 1 → buffer2 is idle, 0 → buffer1 is idle.
- base_addr  in  GB_ADDR_BITWIDTH  global-buffer address for entry 0; sampled on accepted start.
- pe_out1  in  NUM_PE*DATA_BITWIDTH  concatenated `out1` of all PEs; PE k occupies bits [k*DATA_BITWIDTH +: DATA_BITWIDTH].
- pe_out2  in  NUM_PE*DATA_BITWIDTH  concatenated `out2` of all PEs, same packing.
- addr_from_su_adder  out  ADDR_BITWIDTH  read address broadcast to all RFs.
- gb_w_en  out  1  write valid to the global buffer.
- gb_w_addr  out  GB_ADDR_BITWIDTH  write address.
- gb_w_data  out  DATA_BITWIDTH  reduced psum.
- gb_ready  in  1  the global buffer accepts the write on a clock edge where gb_w_en=1 and gb_ready=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last write is accepted.
- overrun  out  1  sticky error: en1 changed during a drain.

## Operation
- States: IDLE, ISSUE, SUM, WRITE, DONE.
- **IDLE**
  - On start=1:
    - latch sel=en1, base=base_addr, idx=0, and clear overrun;
    - go to ISSUE.
  - start is ignored in every other state.
- **ISSUE**
  - addr_from_su_adder = idx, a registered value held stable until idx changes.
  - The RFs register out1/out2 at the end of this cycle.
  - Go to SUM.
- **SUM**
  - Select pe_out2 if sel=1, else pe_out1.
  - Register sum_reg = sum of the NUM_PE words, modulo 2^DATA_BITWIDTH (carries beyond DATA_BITWIDTH are discarded; no saturation).
  - Go to WRITE.
- **WRITE**
  - gb_w_en=1, gb_w_data=sum_reg, gb_w_addr=base+idx (modulo 2^GB_ADDR_BITWIDTH).
  - Hold all three stable until gb_ready=1 at an edge.
  - On acceptance:
    - if idx==DEPTH-1, go to DONE;
    - else idx=idx+1 and go to ISSUE.
- **DONE**
  - done=1 for one cycle, then return to IDLE.
  - addr_from_su_adder keeps its last value in IDLE.
- **Overrun**
  - If en1 != sel in any state other than IDLE or DONE: set overrun=1, deassert gb_w_en and go to IDLE next cycle, with no done pulse.
  - The drained buffer is being cleared by the RF in this case, so its data is invalid.
  - overrun stays 1 until the next accepted start.
- **Reset**
  - reset=0 at any time forces IDLE immediately (asynchronously).
  - An in-flight write is dropped.

## Timing
- Reset values:
  - addr_from_su_adder=0, gb_w_en=0, gb_w_addr=0, gb_w_data=0;
  - busy=0, done=0, overrun=0;
  - idx=0, sum_reg=0, sel=0, base=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- start at edge t gives: ISSUE in cycle t+1, SUM in t+2, first gb_w_en=1 in t+3.
- Per-entry cost is 3 cycles plus the number of gb_ready stall cycles.
- With gb_ready tied to 1, a pass takes 3*DEPTH cycles of busy, then 1 DONE cycle.
  - DEPTH=4: busy for 13 cycles including DONE; done in cycle t+13.
- The RF read latency of 1 cycle is fixed; the RF must be in its non-en (drain) half for the whole pass.

## Test plan
- NUM_PE=4, en1=1, all PEs' buffer2 entries [10,20,30,40], gb_ready=1, base_addr=0x10, start → writes (0x10,40),(0x11,80),(0x12,120),(0x13,160); done pulses exactly 13 cycles after start.
- Same data in buffer1 with en1=0 → identical writes taken from pe_out1; pe_out2 is driven with garbage and has no effect.
- gb_ready low for 3 cycles on the second write → gb_w_en/addr/data held constant for 4 cycles; total pass is 16 cycles; no entry duplicated or skipped.
- Per-PE value 0x6000, NUM_PE=4 → gb_w_data=0x8000 (wrap modulo 2^16); base_addr=0xFE → addresses 0xFE,0xFF,0x00,0x01.
- en1 toggled during the second SUM → overrun=1 next cycle, gb_w_en=0, no done; a subsequent start clears overrun and completes normally.
- reset=0 asserted mid-WRITE → all outputs reach their reset values without waiting for a clock edge; start pulsed while busy is ignored.
